// File: rtl/piso_74x165_tx.sv
// piso_74x165_tx: 74x165-style parallel-in/serial-out transmitter with a
// valid/ready word intake and a one-cycle done pulse after the last bit.
// Bits leave MSB first; shift_en low freezes the shifter like CLK INH.
module piso_74x165_tx #(
    parameter int WIDTH = 8,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [CW-1:0]    cnt;

    // Shift-register contents after one 74x165 clock: move toward the MSB and
    // take ser_in at the LSB. A one-bit register simply becomes ser_in.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shifted = ser_in;
        end else begin : g_wn
            assign sr_shifted = {sr[WIDTH-2:0], ser_in};
        end
    endgenerate

    // Framing FSM; every output is a register updated together with the state
    // so nothing combinational reaches the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sr        <= data_in;
                        cnt       <= CW'(WIDTH - 1);
                        state     <= SHIFT;
                        ready_out <= 1'b0;
                        ser_valid <= 1'b1;
                        ser_out   <= data_in[WIDTH-1];
                    end
                end
                SHIFT: begin
                    // Without shift_en everything holds, so the bit stays put.
                    if (shift_en) begin
                        if (cnt != '0) begin
                            sr      <= sr_shifted;
                            cnt     <= cnt - CW'(1);
                            ser_out <= sr_shifted[WIDTH-1];
                        end else begin
                            // Last bit consumed: no extra shift, no counter wrap.
                            state     <= DONE;
                            ser_valid <= 1'b0;
                            ser_out   <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    ready_out <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    done      <= 1'b0;
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_74x165_tx.sv
// Testbench for piso_74x165_tx: three instances (WIDTH 8, 1, 32) each with a
// driver that pushes the expected serial stream into a queue on every accepted
// handshake, and a monitor that pops and compares on every negative edge.
module tb_piso_74x165_tx;

    logic clk;
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check steps the two summary counters.
    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    localparam int DONE_MARK = 2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g
            localparam int W = (gi == 0) ? 8 : (gi == 1) ? 1 : 32;

            logic         rst;
            logic [W-1:0] data_in;
            logic         valid_in;
            logic         ready_out;
            logic         shift_en;
            logic         ser_in;
            logic         ser_out;
            logic         ser_valid;
            logic         done;
            bit           rand_mode;
            bit           fin;
            int           exp_q[$];
            logic [W-1:0] words[$];
            longint       last_accept;

            piso_74x165_tx #(.WIDTH(W)) dut (
                .clk       (clk),
                .rst       (rst),
                .data_in   (data_in),
                .valid_in  (valid_in),
                .ready_out (ready_out),
                .shift_en  (shift_en),
                .ser_in    (ser_in),
                .ser_out   (ser_out),
                .ser_valid (ser_valid),
                .done      (done)
            );

            // Reference model: a word becomes its bits MSB first, then one done.
            task automatic push_word(input logic [W-1:0] d);
                for (int i = W - 1; i >= 0; i--) exp_q.push_back(int'(d[i]));
                exp_q.push_back(DONE_MARK);
            endtask

            // Feed the pending words, one inspection per clock, bounded by budget.
            task automatic run(input int budget);
                int n;
                bit rdy;
                n = 0;
                while ((words.size() > 0 || exp_q.size() > 0) && n < budget) begin
                    @(negedge clk);
                    rdy = ready_out;
                    @(posedge clk);
                    n++;
                    if (rdy && valid_in) begin
                        push_word(data_in);
                        if (!rand_mode && last_accept >= 0)
                            check($sformatf("w%0d_word_period", W),
                                  ($time - last_accept) / 10, W + 2);
                        last_accept = $time;
                        if (words.size() > 0) void'(words.pop_front());
                    end
                    #1;
                    shift_en = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                    ser_in   = 1'($urandom);
                    if (ready_out || done) begin
                        if (words.size() > 0) begin
                            valid_in = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                            data_in  = words[0];
                        end else begin
                            valid_in = 1'b0;
                        end
                    end else begin
                        // Busy: offer a competing word that must be ignored.
                        valid_in = rand_mode ? 1'($urandom) : 1'b1;
                        data_in  = rand_mode ? W'($urandom) : '1;
                    end
                end
                check($sformatf("w%0d_run_timeout", W), (n >= budget) ? 1 : 0, 0);
            endtask

            // Stimulus: reset, directed words, mid-word reset, random words.
            initial begin
                rst = 1'b1; valid_in = 1'b0; data_in = '0; shift_en = 1'b0;
                ser_in = 1'b0; rand_mode = 1'b0; fin = 1'b0; last_accept = -1;
                #3;
                check($sformatf("w%0d_reset_state", W),
                      {ready_out, ser_valid, ser_out, done}, 4'b1000);
                @(posedge clk);
                #1 rst = 1'b0;

                if (W == 8) begin
                    words.push_back(W'(32'hA5));
                    words.push_back(W'(32'hC3));
                    words.push_back(W'(32'h0F));
                    words.push_back(W'(32'h81));
                    words.push_back(W'(32'h7E));
                end else if (W == 1) begin
                    words.push_back(W'(32'h1));
                    words.push_back(W'(32'h0));
                end else begin
                    words.push_back(W'(32'h8000_0001));
                    words.push_back(W'(32'h7FFF_FFFE));
                end
                run(400);

                // Asynchronous reset in the middle of a word: no done may follow.
                check($sformatf("w%0d_pre_reset_ready", W), ready_out, 1);
                valid_in = 1'b1;
                data_in  = W'($urandom);
                shift_en = 1'b1;
                @(posedge clk);
                push_word(data_in);
                #1 valid_in = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
                exp_q.delete();
                #1;
                check($sformatf("w%0d_async_reset", W),
                      {ready_out, ser_valid, ser_out, done}, 4'b1000);
                @(posedge clk);
                #1 rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check($sformatf("w%0d_ready_after_reset", W), ready_out, 1);

                rand_mode = 1'b1;
                for (int k = 0; k < ((W == 32) ? 10 : 30); k++) words.push_back(W'($urandom));
                run(4000);
                fin = 1'b1;
            end

            // Monitor: compare every cycle against the head of the expected queue.
            always @(negedge clk) begin
                int front;
                front = (exp_q.size() > 0) ? exp_q[0] : -1;
                if (ser_valid) begin
                    check($sformatf("w%0d_ser_out", W), ser_out, front);
                    check($sformatf("w%0d_shift_flags", W), {ready_out, done}, 0);
                    if (shift_en && exp_q.size() > 0 && front != DONE_MARK)
                        void'(exp_q.pop_front());
                end else if (done) begin
                    check($sformatf("w%0d_done_pos", W), front, DONE_MARK);
                    check($sformatf("w%0d_done_flags", W), {ready_out, ser_out}, 0);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    check($sformatf("w%0d_idle_flags", W), {ready_out, ser_out}, 2'b10);
                    check($sformatf("w%0d_idle_pending", W), exp_q.size(), 0);
                end
            end
        end
    endgenerate

    initial begin
        vectors = 0;
        miscompares = 0;
        fork
            wait (g[0].fin && g[1].fin && g[2].fin);
            #400000;
        join_any
        disable fork;
        check("all_done_in_time", (g[0].fin && g[1].fin && g[2].fin) ? 1 : 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_74x165_tx.md
Name: piso_74x165_tx

Overview:
- Parallel-to-serial transmitter modelled on 74x165 behaviour (parallel load, MSB-first shift, clock-inhibit pacing), wrapped in a small handshake/framing controller.
- Drives a serial link whose far end is a 74x164-style serial-in/parallel-out receiver chain.
- Accepts one WIDTH-bit word per valid/ready handshake and emits it bit by bit. Shifting pauses whenever the consumer deasserts shift_en.

Parameters:
- WIDTH, 8, word length in bits; legal range 1..32.
- CW, $clog2(WIDTH) (minimum 1), width of the bit counter.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  parallel word; sampled only on an accepted handshake.
- valid_in  in  1  producer has a word on data_in.
- ready_out  out  1  block can accept a word this cycle.
- shift_en  in  1  consumer accepts the current bit; low acts as 74x165 CLK INH.
- ser_in  in  1  fill bit shifted into the LSB end (74x165 SER pin, for cascading).
- ser_out  out  1  current serial bit (74x165 QH).
- ser_valid  out  1  ser_out holds a valid data bit.
- done  out  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset: rst high forces the following immediately, regardless of clk, and holds them while rst is high.
  - state=IDLE, shift register=0, counter=0.
  - ser_out=0, ser_valid=0, done=0, ready_out=1.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready_out=1, ser_valid=0, ser_out=0.
  - When valid_in=1 at a rising edge: sr<=data_in, cnt<=WIDTH-1, go to SHIFT.
  - When valid_in=0: remain in IDLE.
- SHIFT:
  - ready_out=0, ser_valid=1, ser_out=sr[WIDTH-1] (MSB first).
  - Edge with shift_en=1 and cnt!=0: sr<={sr[WIDTH-2:0],ser_in}, cnt<=cnt-1.
  - Edge with shift_en=1 and cnt==0: go to DONE; sr is not shifted.
  - Edge with shift_en=0: hold sr, cnt and state; the bit on ser_out stays stable for any number of cycles.
- DONE:
  - done=1, ser_valid=0, ready_out=0, ser_out=0, for exactly one cycle.
  - Unconditionally return to IDLE.
- Latency: with shift_en held at 1 and the handshake accepted at edge N:
  - the MSB is on ser_out in cycle N+1;
  - bit i (counting from the MSB) is on ser_out in cycle N+1+i;
  - done=1 in cycle N+WIDTH+1;
  - ready_out=1 again in cycle N+WIDTH+2.
  - Minimum word period is WIDTH+2 cycles.
- valid_in is ignored outside IDLE, and data_in changes outside IDLE have no effect; the producer must hold its word until ready_out=1.
- WIDTH=1: SHIFT lasts one consumed bit (cnt starts at 0), then DONE.
- ser_in only affects bits shifted in after the load. Those bits never reach ser_out within a word, because exactly WIDTH bits are emitted. They are observable only through the internal sr, kept for cascading parity with 74x165.
- Reset mid-word: the word is discarded without a done pulse, and ready_out=1 once rst is released.
- Counter must not wrap: there is no decrement at cnt==0.

Test Plan:
- Reset: assert rst mid-SHIFT asynchronously (between edges) -> ser_valid and ser_out drop to 0 and ready_out rises to 1 before the next edge; no done pulse.
- Basic word: WIDTH=8, data_in=8'hA5, valid_in pulse, shift_en=1 -> ser_out sequence 1,0,1,0,0,1,0,1 in cycles N+1..N+8; done=1 in cycle N+9 only; ready_out=1 in cycle N+10.
- Stall: data 8'hC3, shift_en low for 3 cycles after bit 2 -> bit 2 value (0) held with ser_valid=1 for 4 cycles; full sequence 1,1,0,0,0,0,1,1 unchanged; done delayed by 3 cycles.
- Ignored input: during SHIFT of 8'h0F, drive valid_in=1 with data_in=8'hFF -> output sequence stays 0,0,0,0,1,1,1,1; ready_out=0 throughout SHIFT and DONE.
- Back-to-back: valid_in held at 1 with words 8'h81 then 8'h7E -> second accept occurs at the edge ending the first ready_out=1 cycle; period is 10 cycles; both bit streams are correct.
- Edge width: WIDTH=1, data_in=1'b1 -> ser_out=1 for one cycle, done the next cycle, ready_out the cycle after; WIDTH=32 with data 32'h8000_0001 -> 1, thirty 0s, 1.
